// File: rtl/hazard_scheduler.sv
// hazard_scheduler: pipeline hazard controller for the 5-stage RISC-V core.
// It drives the front-end write enables, bubbles and flushes. It also owns the
// fixed-latency mul/div unit's issue handshake, latency counter, destination
// scoreboard and its single-cycle claim of the register-file write port.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds the StallCycles output. This is
// a saturating count of cycles in which the PC was not updated.

module hazard_scheduler #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  IDRS1,
    input  logic [4:0]  IDRS2,
    input  logic        IDEXMemRead,
    input  logic [4:0]  IDEXRD,
    input  logic        EXMDStart,
    input  logic [4:0]  EXMDRD,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXBubble,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        PipeFreeze,
    output logic        MDBusy,
    output logic        MDWriteEn,
`ifdef HAZARD_PERF_CNT_EN
    output logic [4:0]  MDWriteRD,
    output logic [31:0] StallCycles
`else
    output logic [4:0]  MDWriteRD
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } md_state_t;

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       pending_q, pending_d;

    logic mdAccept;
    logic structStall;
    logic freeze;
    logic loadUse;
    logic pendingHit;
    logic acceptHit;
    logic decodeStall;

    // Hazard detection terms that feed the output priority logic.
    always_comb begin
        mdAccept    = EXMDStart && (state_q == IDLE);
        structStall = EXMDStart && (state_q != IDLE);
        freeze      = structStall || (state_q == WB);
        loadUse     = IDEXMemRead && (IDEXRD != 5'd0)
                      && ((IDEXRD == IDRS1) || (IDEXRD == IDRS2));
        pendingHit  = pending_q[IDRS1] || pending_q[IDRS2];
        acceptHit   = mdAccept && (EXMDRD != 5'd0)
                      && ((EXMDRD == IDRS1) || (EXMDRD == IDRS2));
        decodeStall = loadUse || pendingHit || acceptHit;
    end

    // The mul/div sequencer's next state. It accepts in IDLE, counts down in
    // BUSY, and then spends exactly one cycle in WB holding the write port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (mdAccept) begin
                    rd_d    = EXMDRD;
                    cnt_d   = CNT_W'(MD_LATENCY - 1);
                    state_d = BUSY;
                    if (EXMDRD != 5'd0) begin
                        pending_d[EXMDRD] = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB: begin
                pending_d[rd_q] = 1'b0;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // x0 is hard-wired to zero, so it can never be a real hazard.
        pending_d[0] = 1'b0;
    end

    // Mul/div state, counter, latched destination and scoreboard registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= 5'd0;
            pending_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            pending_q <= pending_d;
        end
    end

    // Front-end control uses this priority: a freeze first, then a taken-branch
    // flush, then a decode stall. While reset is held, the front end runs freely.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        PipeFreeze = 1'b0;
        if (!reset_n) begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
        end else if (freeze) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            PipeFreeze = 1'b1;
        end else if (BranchTaken) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (decodeStall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end
    end

    // Mul/div status and write-port claim, all derived from registered state.
    always_comb begin
        MDBusy    = (state_q != IDLE);
        MDWriteEn = (state_q == WB);
        MDWriteRD = rd_q;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCycles_q, stallCycles_d;

    // Saturating count of every cycle in which the PC was held.
    always_comb begin
        stallCycles_d = stallCycles_q;
        if (!PCWrite && (stallCycles_q != 32'hFFFF_FFFF)) begin
            stallCycles_d = stallCycles_q + 32'd1;
        end
    end

    // Register for the stall-cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCycles_q <= 32'd0;
        end else begin
            stallCycles_q <= stallCycles_d;
        end
    end

    assign StallCycles = stallCycles_q;
`endif

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core. Sits beside the operand-forwarding logic and sequences the front end with PC/IF-ID write enables, bubbles and flushes.
- Resolves load-use hazards, taken-branch flushes and dependencies on a fixed-latency multi-cycle mul/div unit.
- Owns the mul/div unit's issue handshake, latency counter, register scoreboard and its one-cycle claim of the register-file write port.

Parameters:
MD_LATENCY, 4, cycles from mul/div accept to result writeback; legal range 2..16
CNT_W, 4, width of latency down-counter; must satisfy 2^CNT_W > MD_LATENCY

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous, active-low reset
IDRS1  in  5  rs1 of instruction in ID
IDRS2  in  5  rs2 of instruction in ID
IDEXMemRead  in  1  instruction in EX is a load
IDEXRD  in  5  rd of instruction in EX
EXMDStart  in  1  mul/div op valid in EX this cycle
EXMDRD  in  5  rd of that mul/div op
BranchTaken  in  1  branch/jump in EX resolved taken
PCWrite  out  1  PC update enable
IFIDWrite  out  1  IF/ID register write enable
IDEXBubble  out  1  insert NOP into ID/EX (decode stall)
IFIDFlush  out  1  clear IF/ID
IDEXFlush  out  1  clear ID/EX
PipeFreeze  out  1  hold all pipeline registers (IF through MEM/WB)
MDBusy  out  1  mul/div unit occupied (state != IDLE)
MDWriteEn  out  1  mul/div result owns regfile write port this cycle
MDWriteRD  out  5  destination of mul/div result

Behaviour:
- FSM states: IDLE, BUSY, WB. Registered: state, CNT_W-bit counter, latched rd (5b), 32-bit Pending scoreboard.
- Accept: EXMDStart=1 and state=IDLE. On accept:
  - latch EXMDRD.
  - counter <= MD_LATENCY-1.
  - go BUSY.
  - set Pending[EXMDRD] if EXMDRD != 0.
- BUSY: if counter==1, go WB; otherwise decrement.
- WB, exactly one cycle:
  - MDWriteEn=1, MDWriteRD=latched rd, PipeFreeze=1 (the normal MEM/WB writeback is held, so there is no port collision).
  - clear Pending[latched rd].
  - return to IDLE.
- Latency: accept in cycle 0 means MDWriteEn=1 in cycle MD_LATENCY. Back-to-back: the next accept is possible in cycle MD_LATENCY+1.
- Structural stall: EXMDStart=1 while state != IDLE forces PipeFreeze=1. The op is held in EX and is accepted in the first IDLE cycle.
- MDWriteRD holds the last latched value when MDWriteEn=0. An rd=0 op still runs the full FSM, asserts MDWriteEn, and never sets Pending.
- Pending[0] is always 0.
- Decode stall (DS) is asserted if any of the following holds:
  - IDEXMemRead && IDEXRD != 0 && (IDEXRD == IDRS1 || IDEXRD == IDRS2)
  - Pending[IDRS1] || Pending[IDRS2]
  - an accept this cycle with EXMDRD != 0 matching IDRS1 or IDRS2
- Output priority, highest first:
  1. PipeFreeze=1: PCWrite=0, IFIDWrite=0, no bubble, no flush. BranchTaken is ignored because EX is held and re-presents the branch.
  2. BranchTaken: IFIDFlush=1, IDEXFlush=1, PCWrite=1, IFIDWrite=1. DS is ignored because the ID instruction is wrong-path.
  3. DS: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  4. Otherwise: PCWrite=1, IFIDWrite=1, all others 0.
- An accept cannot coincide with a clear of the same scoreboard bit, since clears happen only in WB and accepts only in IDLE.
- Reset:
  - reset_n low asynchronously forces state=IDLE, counter=0, latched rd=0, Pending=0.
  - Outputs while in reset: PCWrite=1, IFIDWrite=1, all other outputs 0.
  - Reset mid-operation discards the in-flight mul/div result; MDWriteEn never fires for it.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds output StallCycles [31:0].
  - Increments each cycle PCWrite=0 (freeze or decode stall).
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by reset_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Load x5 in EX (IDEXMemRead=1, IDEXRD=5), ID reads IDRS1=5 -> one cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1. Same with IDEXRD=0 -> no stall.
2. Accept mul rd=7 at cycle 0 (MD_LATENCY=4); ID reads x7 from cycle 0 -> DS each cycle 0..3. Cycle 4: MDWriteEn=1, MDWriteRD=7, PipeFreeze=1. Cycle 5: no stall, MDBusy=0.
3. EXMDStart=1 again at cycle 2 of an in-flight op -> PipeFreeze=1 cycles 2..4, accept at cycle 5, MDWriteEn at cycle 9.
4. BranchTaken=1 together with a load-use DS -> IFIDFlush=IDEXFlush=1, PCWrite=1, IDEXBubble=0. BranchTaken=1 during WB -> only PipeFreeze=1, no flush.
5. Assert reset_n=0 in cycle 2 of BUSY -> MDBusy=0 immediately, Pending=0, no MDWriteEn after release, ID read of old rd not stalled.
6. With HAZARD_PERF_CNT_EN defined, run scenario 2 -> StallCycles=5 (4 DS + 1 freeze).
